// File: rtl/qspi_pkg.sv
// Shared types for the QSPI receive packer: FSM states, byte width and byte type.
package qspi_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/qspi_skid_buf.sv
// Two-entry byte buffer between the packer shift register and the async FIFO.
// A push while full is refused unless a pop happens in the same cycle, in which
// case the popped slot is reused; a refused push is reported on 'drop'.
module qspi_skid_buf
  import qspi_pkg::*;
(
  input  logic  w_clk,
  input  logic  w_rst_n,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output byte_t head,
  output logic  empty,
  output logic  drop
);

  byte_t       mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        pop_ok;
  logic        push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign drop    = push && !push_ok;
  assign head    = mem[rd_ptr];
  assign empty   = (count == 2'd0);

  // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qspi_rx_packer.sv
// QSPI receive packer: gathers 1-bit or 4-bit beats into bytes and writes them
// to an async FIFO through a two-entry buffer.
// Optional feature macro QSPI_RX_PAD_EN: when defined, a partial byte left at
// frame_end is zero-padded and written; otherwise it is discarded.
module qspi_rx_packer
  import qspi_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 in_valid,
  input  logic                 in_quad,
  input  logic [3:0]           in_nibble,
  input  logic                 full,
  input  logic                 clr_ovf,
  output logic                 w_en,
  output logic [7:0]           wdata,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] byte_cnt,
  output logic                 overflow
);

`ifdef QSPI_RX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t      state_q;
  state_t      state_d;
  logic        quad_q;
  byte_t       sr_q;
  logic [3:0]  bit_cnt_q;

  byte_t       sr_shift;
  logic [3:0]  cnt_shift;
  logic        beat;
  logic        byte_done;
  logic        start_acc;
  logic        end_in_shift;
  logic        push;
  byte_t       push_data;
  byte_t       head;
  logic        buf_empty;
  logic        drop;

  // A frame_start in SHIFT restarts the frame, so a beat in that cycle is lost.
  assign beat         = (state_q == ST_SHIFT) && in_valid && !frame_start;
  assign start_acc    = frame_start && (state_q != ST_FLUSH);
  assign end_in_shift = (state_q == ST_SHIFT) && frame_end && !frame_start;
  assign byte_done    = beat && (cnt_shift == 4'd8);

  // Shift register contents and fill level as they would be after this cycle's beat.
  always_comb begin
    sr_shift  = sr_q;
    cnt_shift = bit_cnt_q;
    if (beat) begin
      if (quad_q) begin
        sr_shift  = MSB_FIRST ? {sr_q[3:0], in_nibble} : {in_nibble, sr_q[7:4]};
        cnt_shift = bit_cnt_q + 4'd4;
      end else begin
        sr_shift  = MSB_FIRST ? {sr_q[6:0], in_nibble[0]} : {in_nibble[0], sr_q[7:1]};
        cnt_shift = bit_cnt_q + 4'd1;
      end
    end
  end

  // Choose what enters the buffer: a completed byte, or a padded partial byte at frame_end.
  always_comb begin
    push      = byte_done;
    push_data = sr_shift;
    if (PAD_EN && end_in_shift && !byte_done && (cnt_shift != 4'd0)) begin
      push      = 1'b1;
      push_data = MSB_FIRST ? byte_t'(sr_shift << (4'd8 - cnt_shift))
                            : byte_t'(sr_shift >> (4'd8 - cnt_shift));
    end
  end

  qspi_skid_buf u_buf (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (w_en),
    .head      (head),
    .empty     (buf_empty),
    .drop      (drop)
  );

  assign w_en       = !buf_empty && !full;
  assign wdata      = buf_empty ? 8'h00 : head;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_FLUSH) && buf_empty;

  // FSM state register.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; FLUSH waits for the buffer to drain before returning to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = frame_end ? ST_FLUSH : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (frame_end) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (buf_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat accumulation; a new frame or frame_end drops any partial byte.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      quad_q    <= 1'b0;
      sr_q      <= '0;
      bit_cnt_q <= 4'd0;
    end else if (start_acc) begin
      quad_q    <= in_quad;
      sr_q      <= '0;
      bit_cnt_q <= 4'd0;
    end else if (end_in_shift) begin
      bit_cnt_q <= 4'd0;
    end else if (beat) begin
      sr_q      <= sr_shift;
      bit_cnt_q <= byte_done ? 4'd0 : cnt_shift;
    end
  end

  // Per-frame count of bytes handed to the FIFO, saturating at all-ones.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      byte_cnt <= '0;
    end else if (start_acc) begin
      byte_cnt <= '0;
    end else if (w_en && (byte_cnt != '1)) begin
      byte_cnt <= byte_cnt + CNT_ONE;
    end
  end

  // Sticky overflow; a new drop in the same cycle as clr_ovf keeps it set.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qspi_rx_packer.sv
// Bench for qspi_rx_packer: one MSB-first and one LSB-first instance share the
// stimulus; a bit-list/byte-queue model predicts every output each cycle.
// Honours QSPI_RX_PAD_EN the same way the design does.
module tb_qspi_rx_packer;

  logic        w_clk = 1'b0;
  logic        w_rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_quad = 1'b0;
  logic [3:0]  in_nibble = 4'h0;
  logic        full = 1'b0;
  logic        clr_ovf = 1'b0;

  logic        w_en_m, w_en_l;
  logic [7:0]  wdata_m, wdata_l;
  logic        busy_m, busy_l;
  logic        done_m, done_l;
  logic [15:0] cnt_m, cnt_l;
  logic        ovf_m, ovf_l;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 w_clk = ~w_clk;

  qspi_rx_packer #(.CNT_WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .in_valid(in_valid), .in_quad(in_quad), .in_nibble(in_nibble), .full(full),
    .clr_ovf(clr_ovf), .w_en(w_en_m), .wdata(wdata_m), .busy(busy_m),
    .frame_done(done_m), .byte_cnt(cnt_m), .overflow(ovf_m)
  );

  qspi_rx_packer #(.CNT_WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .in_valid(in_valid), .in_quad(in_quad), .in_nibble(in_nibble), .full(full),
    .clr_ovf(clr_ovf), .w_en(w_en_l), .wdata(wdata_l), .busy(busy_l),
    .frame_done(done_l), .byte_cnt(cnt_l), .overflow(ovf_l)
  );

  // Model state, index 0 = MSB-first instance, 1 = LSB-first instance.
  // phase: 0 idle, 1 collecting, 2 draining.
  int          m_phase [2];
  bit          m_quad  [2];
  bit          m_bits  [2][8];
  int          m_nbits [2];
  logic [7:0]  m_fifo  [2][2];
  int          m_fsize [2];
  logic [15:0] m_cnt   [2];
  bit          m_ovf   [2];

  logic [7:0]  log_m [$];
  logic [7:0]  log_l [$];
  int          done_seen [2];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Bits arrive in order; MSB-first places arrival i at bit 7-i, LSB-first at bit i.
  function automatic logic [7:0] formByte(input int d, input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (m_bits[d][i]) r[(d == 0) ? (7 - i) : i] = 1'b1;
    end
    return r;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_quad[d] = 1'b0; m_nbits[d] = 0; m_fsize[d] = 0;
      m_cnt[d] = 16'h0; m_ovf[d] = 1'b0;
      m_fifo[d][0] = 8'h00; m_fifo[d][1] = 8'h00;
    end
  endtask

  task automatic modelPush(input int d, input logic [7:0] b);
    if (m_fsize[d] < 2) begin
      m_fifo[d][m_fsize[d]] = b;
      m_fsize[d]++;
    end else begin
      m_ovf[d] = 1'b1;
    end
  endtask

  task automatic modelStart(input int d);
    m_quad[d]  = in_quad;
    m_nbits[d] = 0;
    m_cnt[d]   = 16'h0;
    m_phase[d] = frame_end ? 2 : 1;
  endtask

  task automatic modelStep(input int d);
    int pre;
    pre = m_fsize[d];
    if (pre > 0 && !full) begin
      m_fifo[d][0] = m_fifo[d][1];
      m_fsize[d]--;
      if (m_cnt[d] != 16'hFFFF) m_cnt[d]++;
    end
    if (clr_ovf) m_ovf[d] = 1'b0;
    if (m_phase[d] == 0) begin
      if (frame_start) modelStart(d);
    end else if (m_phase[d] == 1) begin
      if (frame_start) begin
        modelStart(d);
      end else begin
        if (in_valid) begin
          if (m_quad[d]) begin
            for (int k = 0; k < 4; k++) begin
              m_bits[d][m_nbits[d]] = in_nibble[(d == 0) ? (3 - k) : k];
              m_nbits[d]++;
            end
          end else begin
            m_bits[d][m_nbits[d]] = in_nibble[0];
            m_nbits[d]++;
          end
          if (m_nbits[d] == 8) begin
            modelPush(d, formByte(d, 8));
            m_nbits[d] = 0;
          end
        end
        if (frame_end) begin
`ifdef QSPI_RX_PAD_EN
          if (m_nbits[d] > 0) modelPush(d, formByte(d, m_nbits[d]));
`endif
          m_nbits[d] = 0;
          m_phase[d] = 2;
        end
      end
    end else begin
      if (pre == 0) m_phase[d] = 0;
    end
  endtask

  // Model advances on every rising edge and is cleared immediately by reset.
  initial begin
    modelReset();
    forever begin
      @(posedge w_clk or negedge w_rst_n);
      if (!w_rst_n) modelReset();
      else for (int d = 0; d < 2; d++) modelStep(d);
    end
  end

  // Every falling edge: compare both instances against the model and log writes.
  initial begin
    logic        a_wen [2];
    logic [7:0]  a_wd  [2];
    logic        a_busy[2];
    logic        a_done[2];
    logic [15:0] a_cnt [2];
    logic        a_ovf [2];
    string       tag;
    forever begin
      @(negedge w_clk);
      a_wen[0] = w_en_m;  a_wd[0] = wdata_m; a_busy[0] = busy_m; a_done[0] = done_m;
      a_cnt[0] = cnt_m;   a_ovf[0] = ovf_m;
      a_wen[1] = w_en_l;  a_wd[1] = wdata_l; a_busy[1] = busy_l; a_done[1] = done_l;
      a_cnt[1] = cnt_l;   a_ovf[1] = ovf_l;
      for (int d = 0; d < 2; d++) begin
        tag = (d == 0) ? "msb" : "lsb";
        checkOutput({tag, " w_en"}, int'(a_wen[d]), int'(m_fsize[d] > 0 && !full));
        checkOutput({tag, " wdata"}, int'(a_wd[d]), (m_fsize[d] > 0) ? int'(m_fifo[d][0]) : 0);
        checkOutput({tag, " busy"}, int'(a_busy[d]), int'(m_phase[d] != 0));
        checkOutput({tag, " frame_done"}, int'(a_done[d]), int'(m_phase[d] == 2 && m_fsize[d] == 0));
        checkOutput({tag, " byte_cnt"}, int'(a_cnt[d]), int'(m_cnt[d]));
        checkOutput({tag, " overflow"}, int'(a_ovf[d]), int'(m_ovf[d]));
        if (a_done[d]) done_seen[d]++;
      end
      if (w_en_m) log_m.push_back(wdata_m);
      if (w_en_l) log_l.push_back(wdata_l);
    end
  end

  function automatic int logAt(input int d, input int i);
    if (d == 0) return (i < log_m.size()) ? int'(log_m[i]) : -1;
    return (i < log_l.size()) ? int'(log_l[i]) : -1;
  endfunction

  task automatic clearLogs();
    log_m.delete();
    log_l.delete();
    done_seen[0] = 0;
    done_seen[1] = 0;
  endtask

  // Drive one cycle of inputs (called #1 after a rising edge); pulses drop afterwards.
  task automatic applyStimulus(input logic fs, input logic fe, input logic v,
                               input logic q, input logic [3:0] nib);
    frame_start = fs; frame_end = fe; in_valid = v; in_quad = q; in_nibble = nib;
    @(posedge w_clk);
    #1;
    frame_start = 1'b0; frame_end = 1'b0; in_valid = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, in_quad, 4'h0);
  endtask

  initial begin
    logic [7:0] sbits;
    done_seen[0] = 0;
    done_seen[1] = 0;
    repeat (2) @(posedge w_clk);
    #1;
    checkOutput("reset w_en", int'(w_en_m), 0);
    checkOutput("reset busy", int'(busy_m), 0);
    checkOutput("reset byte_cnt", int'(cnt_m), 0);
    w_rst_n = 1'b1;
    idle(2);

    // Quad frame A,5,3,C.
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hA);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hC);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    idle(6);
    checkOutput("quad writes", log_m.size(), 2);
    checkOutput("quad byte0", logAt(0, 0), 'hA5);
    checkOutput("quad byte1", logAt(0, 1), 'h3C);
    checkOutput("quad lsb byte0", logAt(1, 0), 'h5A);
    checkOutput("quad lsb byte1", logAt(1, 1), 'hC3);
    checkOutput("quad byte_cnt", int'(cnt_m), 2);
    checkOutput("quad frame_done pulses", done_seen[0], 1);

    // Single-bit frame 1,0,1,1,0,0,1,0.
    clearLogs();
    sbits = 8'b1011_0010;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, {3'b000, sbits[i]});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    idle(4);
    checkOutput("single msb byte", logAt(0, 0), 'hB2);
    checkOutput("single lsb byte", logAt(1, 0), 'h4D);
    checkOutput("single writes", log_m.size(), 1);

    // Three bytes against a full FIFO: third is dropped.
    clearLogs();
    full = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    for (int i = 1; i <= 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'(i));
    idle(1);
    checkOutput("full overflow", int'(ovf_m), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    idle(2);
    checkOutput("full busy", int'(busy_m), 1);
    full = 1'b0;
    idle(5);
    checkOutput("full writes", log_m.size(), 2);
    checkOutput("full byte0", logAt(0, 0), 'h12);
    checkOutput("full byte1", logAt(0, 1), 'h34);
    checkOutput("full lsb byte1", logAt(1, 1), 'h43);
    clr_ovf = 1'b1;
    idle(1);
    checkOutput("clr_ovf", int'(ovf_m), 0);

    // Partial byte at frame_end.
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    idle(4);
`ifdef QSPI_RX_PAD_EN
    checkOutput("pad msb byte", logAt(0, 0), 'hF0);
    checkOutput("pad lsb byte", logAt(1, 0), 'h0F);
`else
    checkOutput("partial writes", log_m.size(), 0);
`endif
    checkOutput("partial frame_done pulses", done_seen[0], 1);

    // Restart mid-byte.
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h7);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    idle(4);
    checkOutput("restart writes", log_m.size(), 1);
    checkOutput("restart byte", logAt(0, 0), 'h12);
    checkOutput("restart byte_cnt", int'(cnt_m), 1);

    // Reset mid-frame with one byte buffered.
    clearLogs();
    full = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
    idle(1);
    checkOutput("pre-reset busy", int'(busy_m), 1);
    w_rst_n = 1'b0;
    #2;
    checkOutput("in-reset busy", int'(busy_m), 0);
    checkOutput("in-reset wdata", int'(wdata_m), 0);
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
    full = 1'b0;
    idle(3);
    checkOutput("post-reset writes", log_m.size(), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h9);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    idle(4);
    checkOutput("post-reset byte", logAt(0, 0), 'h96);

    // Zero-length frame.
    clearLogs();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
    idle(3);
    checkOutput("zero-len frame_done pulses", done_seen[0], 1);
    checkOutput("zero-len byte_cnt", int'(cnt_m), 0);
    checkOutput("zero-len writes", log_m.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
